hazard_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage pipelined core; sits beside the operand-forwarding unit.
- Handles hazards that forwarding cannot resolve:
  - load-use stall;
  - taken-branch flush (branch resolved in EX);
  - data-memory wait freeze, with a timeout.
- Drives the write-enable, bubble and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipeline_pkg.sv | 53 +++++
 rtl/hazard_controller_sat_counter.sv | 28 ++
 rtl/hazard_controller.sv | 116 +++++++++++
 tb/tb_hazard_controller.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, hazard-controller state and the
// operand-usage decode also used by the forwarding unit.
package pipeline_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int WAIT_W = 16;

    typedef enum logic {RUN, MEM_WAIT} hz_state_t;

    typedef struct packed {
        logic rs1;
        logic rs2;
    } rs_use_t;

    // Bit order: pc_write, if_id_write, if_id_flush, id_ex_write,
    // id_ex_bubble, ex_mem_write, mem_wb_bubble.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_bubble;
    } hz_ctl_t;

    localparam hz_ctl_t CTL_NORMAL   = 7'b1101010;
    localparam hz_ctl_t CTL_BRANCH   = 7'b1111110;
    localparam hz_ctl_t CTL_LOAD_USE = 7'b0001110;
    localparam hz_ctl_t CTL_FREEZE   = 7'b0000001;
    localparam hz_ctl_t CTL_RESET    = 7'b0010101;

    function automatic rs_use_t decode_rs_use(input logic [6:0] opcode);
        rs_use_t u;
        u = '0;
        case (opcode)
            OP_R, OP_STORE, OP_BRANCH: begin
                u.rs1 = 1'b1;
                u.rs2 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: u.rs1 = 1'b1;
            default: u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and
// data-memory wait freeze with timeout, plus a stall-cycle counter.
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             mem_wb_bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles
);

    hz_state_t         state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_error_q, mem_error_d;
    hz_ctl_t           ctl;
    rs_use_t           id_use;
    logic              load_use;
    logic              mem_stall;

    assign id_use    = decode_rs_use(id_opcode);
    assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_use.rs1 && (ex_rd == id_rs1)) ||
                        (id_use.rs2 && (ex_rd == id_rs2)));
    assign mem_stall = mem_req && !mem_ready;

    always_comb begin
        ctl         = CTL_NORMAL;
        state_d     = state_q;
        wait_d      = wait_q;
        mem_error_d = 1'b0;
        if (RESET) begin
            ctl = CTL_RESET;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        ctl     = CTL_FREEZE;
                        state_d = MEM_WAIT;
                        wait_d  = WAIT_W'(1);
                    end else if (ex_branch_taken) begin
                        // The ID instruction is squashed, so any load-use match is moot.
                        ctl = CTL_BRANCH;
                    end else if (load_use) begin
                        ctl = CTL_LOAD_USE;
                    end
                end
                MEM_WAIT: begin
                    // The access completes on this edge, so stay frozen even when ready.
                    ctl = CTL_FREEZE;
                    if (mem_ready) begin
                        state_d = RUN;
                        wait_d  = '0;
                    end else if (wait_q == WAIT_W'(TIMEOUT)) begin
                        state_d     = RUN;
                        wait_d      = '0;
                        mem_error_d = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                default: begin
                    ctl     = CTL_FREEZE;
                    state_d = RUN;
                    wait_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= RUN;
            wait_q      <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_error_q <= mem_error_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (CLK),
        .clr_i   (RESET),
        .en_i    (!ctl.pc_write),
        .count_o (stall_cycles)
    );

    assign pc_write      = ctl.pc_write;
    assign if_id_write   = ctl.if_id_write;
    assign if_id_flush   = ctl.if_id_flush;
    assign id_ex_write   = ctl.id_ex_write;
    assign id_ex_bubble  = ctl.id_ex_bubble;
    assign ex_mem_write  = ctl.ex_mem_write;
    assign mem_wb_bubble = ctl.mem_wb_bubble;
    assign mem_error     = mem_error_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed vectors push expected
// controls; a monitor pops and compares each cycle.
module tb_hazard_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic        pc_write, if_id_write, if_id_flush, id_ex_write;
    logic        id_ex_bubble, ex_mem_write, mem_wb_bubble, mem_error;
    logic [31:0] stall_cycles;

    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write;
    logic        s_id_ex_bubble, s_ex_mem_write, s_mem_wb_bubble, s_mem_error;
    logic [2:0]  s_stall_cycles;

    always #5 CLK = ~CLK;

    hazard_controller #(.CNT_W(32), .TIMEOUT(4)) dut (
        .CLK(CLK), .RESET(RESET), .id_opcode(id_opcode), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
        .ex_mem_write(ex_mem_write), .mem_wb_bubble(mem_wb_bubble),
        .mem_error(mem_error), .stall_cycles(stall_cycles)
    );

    hazard_controller #(.CNT_W(3), .TIMEOUT(4)) dut_sat (
        .CLK(CLK), .RESET(RESET), .id_opcode(id_opcode), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
        .id_ex_write(s_id_ex_write), .id_ex_bubble(s_id_ex_bubble),
        .ex_mem_write(s_ex_mem_write), .mem_wb_bubble(s_mem_wb_bubble),
        .mem_error(s_mem_error), .stall_cycles(s_stall_cycles)
    );

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble}
    localparam logic [6:0] NORM = 7'b1101010;
    localparam logic [6:0] BRCH = 7'b1111110;
    localparam logic [6:0] LDU  = 7'b0001110;
    localparam logic [6:0] FRZ  = 7'b0000001;
    localparam logic [6:0] RST  = 7'b0010101;

    localparam logic [6:0] R = 7'b0110011, IMM = 7'b0010011, ST = 7'b0100011, JAL = 7'b1101111;

    typedef struct packed {
        logic [6:0]  ctl;
        logic        err;
        logic [31:0] stall;
        logic [2:0]  stall3;
    } exp_t;

    exp_t        expq[$];
    exp_t        cur;
    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    logic [31:0] exp_stall  = 32'd0;
    logic [2:0]  exp_stall3 = 3'd0;

    task automatic step(input logic rst, input logic [6:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic mr,
                        input logic br, input logic mq, input logic my,
                        input logic [6:0] ctl, input logic err);
        @(negedge CLK);
        RESET = rst; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        ex_mem_read = mr; ex_branch_taken = br; mem_req = mq; mem_ready = my;
        expq.push_back('{ctl, err, exp_stall, exp_stall3});
        if (rst) begin
            exp_stall  = 32'd0;
            exp_stall3 = 3'd0;
        end else if (!ctl[6]) begin
            exp_stall = exp_stall + 32'd1;
            if (exp_stall3 != 3'd7) exp_stall3 = exp_stall3 + 3'd1;
        end
    endtask

    always @(negedge CLK) begin
        #2;
        if (expq.size() > 0) begin
            cur = expq.pop_front();
            cycle++;
            checks++;
            if ({pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
                 ex_mem_write, mem_wb_bubble} != cur.ctl) begin
                errors++;
                $display("FAIL ctl vec %0d: got %b expected %b", cycle,
                         {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
                          ex_mem_write, mem_wb_bubble}, cur.ctl);
            end
            checks++;
            if (mem_error !== cur.err) begin
                errors++;
                $display("FAIL mem_error vec %0d: got %b expected %b", cycle, mem_error, cur.err);
            end
            checks++;
            if (stall_cycles !== cur.stall) begin
                errors++;
                $display("FAIL stall_cycles vec %0d: got %0d expected %0d", cycle, stall_cycles, cur.stall);
            end
            checks++;
            if (s_stall_cycles !== cur.stall3) begin
                errors++;
                $display("FAIL stall_cycles_w3 vec %0d: got %0d expected %0d", cycle, s_stall_cycles, cur.stall3);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1; id_opcode = '0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge CLK);
        //   rst op   rs1 rs2 rd  mr br mq my  ctl   err
        step(1, R,   0,  0,  0,  0, 0, 0, 0, RST,  0);
        step(0, R,   1,  2,  5,  1, 0, 0, 0, NORM, 0);
        step(0, R,   1,  5,  5,  1, 0, 0, 0, LDU,  0);
        step(0, R,   1,  5,  5,  0, 0, 0, 0, NORM, 0);
        step(0, R,   0,  0,  0,  1, 0, 0, 0, NORM, 0);
        step(0, IMM, 3,  7,  7,  1, 0, 0, 0, NORM, 0);
        step(0, IMM, 7,  3,  7,  1, 0, 0, 0, LDU,  0);
        step(0, R,   1,  5,  5,  1, 1, 0, 0, BRCH, 0);
        step(0, ST,  1,  9,  9,  1, 0, 0, 0, LDU,  0);
        step(0, JAL, 9,  9,  9,  1, 0, 0, 0, NORM, 0);
        // memory wait with a branch pending throughout
        step(0, R,   1,  2,  3,  0, 1, 1, 0, FRZ,  0);
        step(0, R,   1,  2,  3,  0, 1, 1, 0, FRZ,  0);
        step(0, R,   1,  2,  3,  0, 1, 1, 0, FRZ,  0);
        step(0, R,   1,  2,  3,  0, 1, 1, 1, FRZ,  0);
        step(0, R,   1,  2,  3,  0, 1, 0, 0, BRCH, 0);
        step(0, R,   1,  2,  3,  0, 0, 0, 0, NORM, 0);
        // timeout with the request held
        step(0, R,   1,  2,  3,  0, 0, 1, 0, FRZ,  0);
        step(0, R,   1,  2,  3,  0, 0, 1, 0, FRZ,  0);
        step(0, R,   1,  2,  3,  0, 0, 1, 0, FRZ,  0);
        step(0, R,   1,  2,  3,  0, 0, 1, 0, FRZ,  0);
        step(0, R,   1,  2,  3,  0, 0, 1, 0, FRZ,  0);
        step(0, R,   1,  2,  3,  0, 0, 1, 0, FRZ,  1);
        step(0, R,   1,  2,  3,  0, 0, 1, 0, FRZ,  0);
        // reset in MEM_WAIT, then RUN with a ready access
        step(1, R,   1,  2,  3,  0, 0, 1, 0, RST,  0);
        step(0, R,   1,  2,  3,  0, 0, 1, 1, NORM, 0);
        step(0, R,   1,  2,  3,  0, 0, 0, 0, NORM, 0);
        @(negedge CLK);
        #4;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
